// File: rtl/schedule_request_arbiter_if.sv
// schedule_request_arbiter_if: scheduler request bus between the arbiter (master) and the scheduler (slave).
//   schedEnabled                    master->slave  high for the duration of one transaction
//   schedHasDeschedule/DeschedulePid master->slave  stable while schedEnabled
//   schedHasSchedule/SchedulePid    master->slave  stable while schedEnabled
//   schedFinished                   slave->master  scheduler has completed the transaction
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 4
`endif
interface schedule_request_arbiter_if #(parameter int addrBits = `ADDRESS_BITS);
  logic                schedEnabled;
  logic                schedHasDeschedule;
  logic [addrBits-1:0] schedDeschedulePid;
  logic                schedHasSchedule;
  logic [addrBits-1:0] schedSchedulePid;
  logic                schedFinished;
  modport master(output schedEnabled, schedHasDeschedule, schedDeschedulePid, schedHasSchedule, schedSchedulePid, input schedFinished);
  modport slave(input schedEnabled, schedHasDeschedule, schedDeschedulePid, schedHasSchedule, schedSchedulePid, output schedFinished);
endinterface

// File: rtl/schedule_request_arbiter.sv
// schedule_request_arbiter: round-robin collects core 0/1 schedule requests into a FIFO and issues them to the scheduler.
//   clk, reset (async active-low); core{0,1}Req* request handshake; core{0,1}Active scheduler status;
//   sched: scheduler bus (master); fifoCount occupancy; busy = FIFO non-empty or transaction in progress.
//   Optional macro IDLE_KICK_EN: issue kick transactions while idle with an empty FIFO and an idle core.
module schedule_request_arbiter #(
  parameter int addrBits   = `ADDRESS_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          core0ReqValid,
  input  logic                          core0ReqDeschedule,
  input  logic [addrBits-1:0]           core0ReqDeschPid,
  input  logic                          core0ReqSchedule,
  input  logic [addrBits-1:0]           core0ReqSchedPid,
  output logic                          core0ReqReady,
  input  logic                          core1ReqValid,
  input  logic                          core1ReqDeschedule,
  input  logic [addrBits-1:0]           core1ReqDeschPid,
  input  logic                          core1ReqSchedule,
  input  logic [addrBits-1:0]           core1ReqSchedPid,
  output logic                          core1ReqReady,
  input  logic                          core0Active,
  input  logic                          core1Active,
  schedule_request_arbiter_if.master    sched,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          busy
);
  localparam int ptrBits = $clog2(FIFO_DEPTH);
  localparam int entBits = 2 * addrBits + 2;
  typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;
  state_t state, nextState;
  logic [FIFO_DEPTH-1:0][entBits-1:0] mem;
  logic [ptrBits-1:0] wrPtr, rdPtr;
  logic [entBits-1:0] pushEntry;
  logic rr, notFull, grant0, grant1, push, pop, kick, issue;
  // ready is gated by reset so that every output reads 0 while reset is held
  always_comb begin
    notFull   = reset && (fifoCount < ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
    grant0    = core0ReqValid && notFull && (!core1ReqValid || !rr);
    grant1    = core1ReqValid && notFull && (!core0ReqValid || rr);
    push      = grant0 || grant1;
    pushEntry = grant0 ? {core0ReqDeschedule, core0ReqDeschPid, core0ReqSchedule, core0ReqSchedPid}
                       : {core1ReqDeschedule, core1ReqDeschPid, core1ReqSchedule, core1ReqSchedPid};
    pop       = state == IDLE && fifoCount != '0 && !sched.schedFinished;
    issue     = pop || kick;
  end
`ifdef IDLE_KICK_EN
  assign kick = state == IDLE && fifoCount == '0 && (!core0Active || !core1Active) && !sched.schedFinished;
`else
  logic unusedActive;
  assign unusedActive = core0Active | core1Active;
  assign kick = 1'b0;
`endif
  assign core0ReqReady = grant0;
  assign core1ReqReady = grant1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      rr        <= 1'b0;
    end else begin
      wrPtr     <= push ? wrPtr + 1'b1 : wrPtr;
      rdPtr     <= pop ? rdPtr + 1'b1 : rdPtr;
      fifoCount <= fifoCount + {{ptrBits{1'b0}}, push} - {{ptrBits{1'b0}}, pop};
      rr        <= grant0 ? 1'b1 : grant1 ? 1'b0 : rr;
    end
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= pushEntry;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = state == IDLE ? (issue ? RUN : IDLE)
              : state == RUN  ? (sched.schedFinished ? COOL : RUN)
              : (sched.schedFinished ? COOL : IDLE);
  always_comb begin
    sched.schedEnabled = state == RUN;
    busy               = fifoCount != '0 || state != IDLE;
  end
  // a kick loads an all-zero entry (no deschedule, no schedule)
  always_ff @(posedge clk or negedge reset)
    if (!reset) {sched.schedHasDeschedule, sched.schedDeschedulePid, sched.schedHasSchedule, sched.schedSchedulePid} <= '0;
    else if (issue) {sched.schedHasDeschedule, sched.schedDeschedulePid, sched.schedHasSchedule, sched.schedSchedulePid} <= pop ? mem[rdPtr] : '0;
endmodule

// File: tb/tb_schedule_request_arbiter.sv
// tb_schedule_request_arbiter: directed and randomized checks against a queue-based transaction model.
module tb_schedule_request_arbiter;
  localparam int AB = 4;
  localparam int DEPTH = 4;
  localparam int VW = 2 * AB + 2 + 1 + 3 + 1;
`ifdef IDLE_KICK_EN
  localparam bit kickEn = 1'b1;
`else
  localparam bit kickEn = 1'b0;
`endif
  typedef struct packed {logic hd; logic [AB-1:0] dp; logic hs; logic [AB-1:0] sp;} ent_t;
  logic clk = 0, reset = 0;
  logic c0v = 0, c0d = 0, c0s = 0, c1v = 0, c1d = 0, c1s = 0, c0a = 1, c1a = 1, fin = 0;
  logic [AB-1:0] c0dp = 0, c0sp = 0, c1dp = 0, c1sp = 0;
  logic c0r, c1r, busy;
  logic [2:0] fifoCount;
  int checks = 0, failures = 0;
  schedule_request_arbiter_if #(.addrBits(AB)) sif();
  assign sif.schedFinished = fin;
  schedule_request_arbiter #(.addrBits(AB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .core0ReqValid(c0v), .core0ReqDeschedule(c0d), .core0ReqDeschPid(c0dp), .core0ReqSchedule(c0s), .core0ReqSchedPid(c0sp), .core0ReqReady(c0r),
    .core1ReqValid(c1v), .core1ReqDeschedule(c1d), .core1ReqDeschPid(c1dp), .core1ReqSchedule(c1s), .core1ReqSchedPid(c1sp), .core1ReqReady(c1r),
    .core0Active(c0a), .core1Active(c1a), .sched(sif), .fifoCount(fifoCount), .busy(busy));
  always #5 clk = ~clk;
  logic [VW-1:0] dutVec;
  assign dutVec = {sif.schedEnabled, sif.schedHasDeschedule, sif.schedDeschedulePid, sif.schedHasSchedule, sif.schedSchedulePid, fifoCount, busy};
  ent_t q[$];
  bit mrr, mEn, mCool;
  ent_t mOut;
  function automatic logic [1:0] expReady();
    bit room = q.size() < DEPTH;
    bit pick1 = (c0v && c1v) ? mrr : c1v;
    return {room && c1v && pick1, room && c0v && !pick1};
  endfunction
  function automatic logic [VW-1:0] expVec();
    return {mEn, mOut, 3'(q.size()), q.size() != 0 || mEn || mCool};
  endfunction
  task automatic modelEdge();
    logic [1:0] g = expReady();
    bit startTx = !mEn && !mCool && !fin;
    if (startTx && q.size() > 0) begin mOut = q.pop_front(); mEn = 1; end
    else if (startTx && kickEn && (!c0a || !c1a)) begin mOut = '0; mEn = 1; end
    else if (mEn && fin) begin mEn = 0; mCool = 1; end
    else if (mCool && !fin) mCool = 0;
    if (g[0]) begin q.push_back({c0d, c0dp, c0s, c0sp}); mrr = 1; end
    else if (g[1]) begin q.push_back({c1d, c1dp, c1s, c1sp}); mrr = 0; end
  endtask
  task automatic cycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask
  task automatic doReset();
    reset = 0;
    {c0v, c0d, c0s, c1v, c1d, c1s, fin} = '0;
    {c0dp, c0sp, c1dp, c1sp} = '0;
    c0a = 1; c1a = 1;
    q.delete(); mrr = 0; mEn = 0; mCool = 0; mOut = '0;
    @(negedge clk);
    reset = 1;
  endtask
  task automatic test_reset();
    reset = 0; c0v = 1; c1v = 1;
    #1;
    checks++; if (dutVec !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", dutVec); end
    checks++; if ({c1r, c0r} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {c1r, c0r}); end
    doReset();
  endtask
  task automatic test_single();
    doReset();
    c0v = 1; c0d = 1; c0dp = 3; c0s = 0;
    #1;
    checks++; if (c0r !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", c0r); end
    cycle();
    c0v = 0;
    checks++; if (dutVec !== expVec() || sif.schedEnabled !== 1'b0) begin failures++; $display("FAIL single_accept got=%h exp=%h", dutVec, expVec()); end
    cycle();
    checks++; if ({sif.schedEnabled, sif.schedHasDeschedule, sif.schedDeschedulePid} !== {2'b11, 4'd3}) begin failures++; $display("FAIL single_issue got=%h exp=%h", dutVec, expVec()); end
    fin = 1;
    cycle();
    checks++; if (sif.schedEnabled !== 1'b0 || dutVec !== expVec()) begin failures++; $display("FAIL single_drop got=%h exp=%h", dutVec, expVec()); end
    fin = 0;
    cycle();
    checks++; if (dutVec !== expVec() || busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%h exp=%h", dutVec, expVec()); end
  endtask
  task automatic test_round_robin();
    logic [AB-1:0] issued[$];
    bit prevEn = 0;
    doReset();
    c0v = 1; c0s = 1; c0sp = 5; c1v = 1; c1s = 1; c1sp = 6;
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++; if ({c1r, c0r} !== expReady()) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", i, {c1r, c0r}, expReady()); end
      cycle();
      checks++; if (dutVec !== expVec()) begin failures++; $display("FAIL rr_state cyc=%0d got=%h exp=%h", i, dutVec, expVec()); end
      if (sif.schedEnabled && !prevEn) issued.push_back(sif.schedSchedulePid);
      prevEn = sif.schedEnabled;
      fin = sif.schedEnabled;
    end
    checks++; if (issued.size() < 4) begin failures++; $display("FAIL rr_count got=%0d exp>=4", issued.size()); end
    foreach (issued[i]) begin
      checks++; if (issued[i] !== ((i % 2) ? 4'd6 : 4'd5)) begin failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, issued[i], (i % 2) ? 6 : 5); end
    end
    c0v = 0; c1v = 0; fin = 0;
  endtask
  task automatic test_full();
    logic [AB-1:0] pid;
    doReset();
    c0v = 1; c0s = 1;
    for (int i = 0; i < 12 && fifoCount != 3'd4; i++) begin
      c0sp = AB'(i + 1);
      #1;
      checks++; if ({c1r, c0r} !== expReady()) begin failures++; $display("FAIL full_ready got=%b exp=%b", {c1r, c0r}, expReady()); end
      cycle();
      checks++; if (dutVec !== expVec()) begin failures++; $display("FAIL full_fill got=%h exp=%h", dutVec, expVec()); end
    end
    checks++; if (fifoCount !== 3'd4 || sif.schedEnabled !== 1'b1) begin failures++; $display("FAIL full_count got=%0d exp=4", fifoCount); end
    pid = sif.schedSchedulePid;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (c0r !== 1'b0) begin failures++; $display("FAIL full_blocked got=%b exp=0", c0r); end
      cycle();
      checks++; if (sif.schedSchedulePid !== pid || fifoCount !== 3'd4) begin failures++; $display("FAIL full_hold got=%0d/%0d exp=%0d/4", sif.schedSchedulePid, fifoCount, pid); end
    end
    fin = 1; cycle();
    fin = 0; cycle();
    cycle();
    #1;
    checks++; if (c0r !== 1'b1 || dutVec !== expVec() || fifoCount !== 3'd3) begin failures++; $display("FAIL full_release got=%h exp=%h", dutVec, expVec()); end
    c0v = 0;
    cycle();
  endtask
  task automatic test_cool();
    doReset();
    c0v = 1; c0s = 1; c0sp = 7; cycle();
    c0sp = 8; cycle();
    c0v = 0; cycle();
    checks++; if (sif.schedEnabled !== 1'b1 || sif.schedSchedulePid !== 4'd7) begin failures++; $display("FAIL cool_first got=%h exp=%h", dutVec, expVec()); end
    fin = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (sif.schedEnabled !== 1'b0 || dutVec !== expVec()) begin failures++; $display("FAIL cool_hold cyc=%0d got=%h exp=%h", i, dutVec, expVec()); end
    end
    fin = 0;
    cycle();
    checks++; if (sif.schedEnabled !== 1'b0) begin failures++; $display("FAIL cool_gap got=%b exp=0", sif.schedEnabled); end
    cycle();
    checks++; if (sif.schedEnabled !== 1'b1 || sif.schedSchedulePid !== 4'd8 || dutVec !== expVec()) begin failures++; $display("FAIL cool_reissue got=%h exp=%h", dutVec, expVec()); end
  endtask
  task automatic test_reset_run();
    doReset();
    c0v = 1; c0s = 1;
    for (int i = 0; i < 3; i++) begin c0sp = AB'(i + 1); cycle(); end
    c0v = 0; cycle();
    checks++; if (sif.schedEnabled !== 1'b1 || fifoCount !== 3'd2) begin failures++; $display("FAIL rstrun_pre got=%h exp=%h", dutVec, expVec()); end
    reset = 0;
    #1;
    checks++; if (dutVec !== '0 || busy !== 1'b0) begin failures++; $display("FAIL rstrun_clear got=%h exp=0", dutVec); end
    doReset();
    c0v = 1; c0s = 1; c0sp = 9; cycle();
    c0v = 0; cycle();
    checks++; if (sif.schedEnabled !== 1'b1 || sif.schedSchedulePid !== 4'd9 || dutVec !== expVec()) begin failures++; $display("FAIL rstrun_after got=%h exp=%h", dutVec, expVec()); end
  endtask
  task automatic test_kick();
    doReset();
    c1a = 0;
    cycle(); cycle();
    checks++; if (sif.schedEnabled !== kickEn || sif.schedHasDeschedule !== 1'b0 || sif.schedHasSchedule !== 1'b0) begin failures++; $display("FAIL kick got=%h exp_en=%b", dutVec, kickEn); end
    checks++; if (dutVec !== expVec()) begin failures++; $display("FAIL kick_model got=%h exp=%h", dutVec, expVec()); end
    c1a = 1;
  endtask
  task automatic test_random();
    doReset();
    for (int i = 0; i < 500; i++) begin
      c0v = 1'($urandom_range(0, 1)); c1v = 1'($urandom_range(0, 1));
      c0d = 1'($urandom); c0s = 1'($urandom); c0dp = AB'($urandom); c0sp = AB'($urandom);
      c1d = 1'($urandom); c1s = 1'($urandom); c1dp = AB'($urandom); c1sp = AB'($urandom);
      c0a = $urandom_range(0, 7) != 0; c1a = $urandom_range(0, 7) != 0;
      fin = $urandom_range(0, 2) == 0;
      #1;
      checks++; if ({c1r, c0r} !== expReady()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, {c1r, c0r}, expReady()); end
      cycle();
      checks++; if (dutVec !== expVec()) begin failures++; $display("FAIL rand_state cyc=%0d got=%h exp=%h", i, dutVec, expVec()); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_cool();
    test_reset_run();
    test_kick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
